// File: rtl/vec_lsu.sv
// Vector load/store sequencer between the vector core and a 16x32-bit block memory.
// Optional define VEC_LSU_ALIGN_CHK_EN also rejects base addresses not aligned to LANES.
module vec_lsu #(
  parameter int         WORD_W    = 32,
  parameter int         LANES     = 16,
  parameter int         ADDR_W    = 9,
  parameter int         MEM_WORDS = 512,
  parameter logic [1:0] IDLE_OP   = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [WORD_W*LANES-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_err,
  output logic [WORD_W*LANES-1:0]   resp_rdata,
  output logic [1:0]                mem_op_code,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORD_W*LANES-1:0]   mem_wr_data,
  input  logic [WORD_W*LANES-1:0]   mem_rd_data
);
  localparam int                DW       = WORD_W * LANES;
  localparam int                AL_W     = $clog2(LANES);
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_WORDS - LANES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_rdata;
  logic                w_accept;
  logic                w_err;

  // A block starting past MAX_BASE would wrap beyond the last memory word.
  always_comb begin
    w_err = (req_addr > MAX_BASE);
`ifdef VEC_LSU_ALIGN_CHK_EN
    w_err = w_err || (req_addr[AL_W-1:0] != '0);
`endif
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = r_write ? S_RESP : S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; ISSUE is only ever entered from IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_op         <= IDLE_OP;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_req_ready  <= (w_next == S_IDLE);
      r_resp_valid <= (w_next == S_RESP);
      r_op         <= (w_next == S_ISSUE) ? {1'b0, req_write} : IDLE_OP;
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_resp_err <= w_err;
      end
      if (r_state == S_WAIT) r_rdata <= mem_rd_data;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_rdata;
  assign mem_op_code = r_op;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;
endmodule

// File: tb/tb_vec_lsu.sv
// Scoreboard bench for vec_lsu with a behavioural block memory.
module tb_vec_lsu;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [8:0]   req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_err;
  logic [511:0] resp_rdata;
  logic [1:0]   mem_op_code;
  logic [8:0]   mem_addr;
  logic [511:0] mem_wr_data;
  logic [511:0] mem_rd_data = '0;

  vec_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .mem_op_code(mem_op_code), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         err;
    logic [511:0] rdata;
  } exp_t;

  exp_t         q[$];
  logic [511:0] last_rd = '0;
  int           checks = 0;
  int           failures = 0;
  int           op_count = 0;
  logic [31:0]  mem [512];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Memory: write or registered read one edge after the op is seen.
  initial for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | i;
  always @(posedge clk) begin
    if (mem_op_code != 2'b11) op_count++;
    if (mem_op_code == 2'b01)
      for (int j = 0; j < 16; j++) mem[9'(mem_addr + 9'(j))] <= mem_wr_data[j*32 +: 32];
    if (mem_op_code == 2'b00)
      for (int j = 0; j < 16; j++) mem_rd_data[j*32 +: 32] <= mem[9'(mem_addr + 9'(j))];
  end

  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic run_req(input string nm, input logic wr, input logic [8:0] addr,
                         input logic [511:0] wd, input logic exp_err,
                         input logic [511:0] exp_rd, input int exp_lat, input int hold);
    exp_t e;
    int   ops0;
    int   seen;
    @(posedge clk); #1;
    chk({nm, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    e.err   = exp_err;
    e.rdata = (exp_err || wr) ? last_rd : exp_rd;
    last_rd = e.rdata;
    q.push_back(e);
    ops0 = op_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 6 && seen == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({nm, " op"}, mem_op_code, exp_err ? 2'b11 : {1'b0, wr});
        if (!exp_err) chk({nm, " addr"}, mem_addr, addr);
      end
      if (resp_valid) seen = c;
    end
    chk({nm, " latency"}, seen, exp_lat);
    // Stall the response while pushing a request that must be ignored.
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_wdata = '1;
      @(negedge clk);
      chk({nm, " hold_valid"}, resp_valid, 1);
      chk({nm, " hold_ready"}, req_ready, 0);
      chk({nm, " hold_rdata"}, resp_rdata, e.rdata);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({nm, " valid_drop"}, resp_valid, 0);
    chk({nm, " op_count"}, op_count - ops0, exp_err ? 0 : 1);
  endtask

  initial begin
    logic [511:0] st_dat;
    logic [511:0] hi_dat;
    logic [511:0] lo_dat;
    int           ops0;
    for (int j = 0; j < 16; j++) begin
      st_dat[j*32 +: 32] = 32'(j + 1);
      hi_dat[j*32 +: 32] = 32'hA000_0000 | 32'(496 + j);
      lo_dat[j*32 +: 32] = 32'hA000_0000 | 32'(8 + j);
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst op", mem_op_code, 2'b11);
    chk("rst rdata", resp_rdata, 0);
    chk("rst addr", mem_addr, 0);

    run_req("store32", 1'b1, 9'd32, st_dat, 1'b0, '0, 2, 0);
    run_req("load32", 1'b0, 9'd32, '0, 1'b0, st_dat, 3, 0);
    run_req("load497", 1'b0, 9'd497, '0, 1'b1, '0, 1, 0);
    run_req("load496", 1'b0, 9'd496, '0, 1'b0, hi_dat, 3, 5);
`ifdef VEC_LSU_ALIGN_CHK_EN
    run_req("load8", 1'b0, 9'd8, '0, 1'b1, '0, 1, 0);
`else
    run_req("load8", 1'b0, 9'd8, '0, 1'b0, lo_dat, 3, 0);
`endif

    // Reset asserted while a load is in ISSUE.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'd64;
    ops0 = op_count;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("abort issue_op", mem_op_code, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort op", mem_op_code, 2'b11);
    chk("abort resp_valid", resp_valid, 0);
    chk("abort req_ready", req_ready, 1);
    chk("abort rdata", resp_rdata, 0);
    repeat (3) @(negedge clk);
    chk("abort op_count", op_count - ops0, 1);
    chk("abort still_idle", resp_valid, 0);
    last_rd = '0;

    run_req("reload32", 1'b0, 9'd32, '0, 1'b0, st_dat, 3, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
